// File: rtl/io_channel_loader_if.sv
// ----------------------------------------------------------------------------
// io_channel_loader_if
// Bundles the serial input, read-select bus and status outputs of the
// io_channel_loader so the top level can pass them as a single port.
//
// Signals
//   rx_serial    UART line into the loader, idle high
//   sel_read     channel read select
//   data_read    selected channel word (0 when sel_read is out of range)
//   ch_data      all channel words, channel k at [k*DATA_W +: DATA_W]
//   frame_valid  1-cycle pulse, a channel was updated
//   frame_err    1-cycle pulse, a frame was discarded
//   err_count    saturating count of discarded frames
//
// Modports
//   master  host side: drives rx_serial and sel_read, observes the rest
//   slave   loader side
// ----------------------------------------------------------------------------
interface io_channel_loader_if #(
    parameter int NUM_CH = 7,
    parameter int DATA_W = 15,
    parameter int SEL_W  = 5
);
    logic                     rx_serial;
    logic [SEL_W-1:0]         sel_read;
    logic [DATA_W-1:0]        data_read;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic                     frame_valid;
    logic                     frame_err;
    logic [7:0]               err_count;

    modport master (
        output rx_serial, sel_read,
        input  data_read, ch_data, frame_valid, frame_err, err_count
    );

    modport slave (
        input  rx_serial, sel_read,
        output data_read, ch_data, frame_valid, frame_err, err_count
    );
endinterface

// File: rtl/io_channel_loader.sv
// ----------------------------------------------------------------------------
// io_channel_loader
// Serial-fed bank of AGC input channels. 8N1 UART bytes arriving on
// bus.rx_serial are assembled into frames:
//   byte0          channel index (must be < NUM_CH)
//   NB data bytes  channel word, big-endian, NB = ceil(DATA_W/8); unused top
//                  bits of the first data byte are ignored
//   [checksum]     XOR of all preceding frame bytes (IO_LOADER_CHECKSUM_EN)
// A complete frame writes its channel register; a bad channel index, a UART
// framing error, an over-long idle gap inside a frame, or a checksum mismatch
// discards the frame and bumps a saturating error counter.
//
// Build option
//   IO_LOADER_CHECKSUM_EN  defined: trailing checksum byte required.
//                          undefined: no checksum byte.
//
// Ports
//   clock  system clock, all logic on posedge
//   reset  asynchronous, active-high
//   bus    io_channel_loader_if.slave (rx_serial, sel_read in; data_read,
//          ch_data, frame_valid, frame_err, err_count out)
// ----------------------------------------------------------------------------
module io_channel_loader #(
    parameter int              NUM_CH       = 7,
    parameter int              DATA_W       = 15,
    parameter int              SEL_W        = 5,
    parameter int              CLKS_PER_BIT = 434,
    parameter int              TIMEOUT_CLKS = 20 * CLKS_PER_BIT,
    parameter logic [DATA_W-1:0] RESET_VAL  = '0
) (
    input logic               clock,
    input logic               reset,
    io_channel_loader_if.slave bus
);
    localparam int NB    = (DATA_W + 7) / 8;
    localparam int ACC_W = NB * 8;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BC_W  = $clog2(NB + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BC_W-1:0]  LAST_DB = BC_W'(NB - 1);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CLKS);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {F_CH, F_DATA, F_CSUM}            frame_state_t;

    // ---------------- rx synchroniser ----------------
    logic sync1, rx_s;

    // NOTE: every clocked register uses <= so all flops update from pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= bus.rx_serial;
            rx_s  <= sync1;
        end
    end

    // ---------------- byte receiver ----------------
    rx_state_t        rx_state, rx_state_n;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       rx_byte, rx_byte_n;
    logic             byte_stb, byte_stb_n;
    logic             rx_ferr, rx_ferr_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_state <= R_IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            rx_byte  <= '0;
            byte_stb <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            clk_cnt  <= clk_cnt_n;
            bit_idx  <= bit_idx_n;
            rx_byte  <= rx_byte_n;
            byte_stb <= byte_stb_n;
            rx_ferr  <= rx_ferr_n;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        rx_state_n = rx_state;
        clk_cnt_n  = clk_cnt + 1'b1;
        bit_idx_n  = bit_idx;
        rx_byte_n  = rx_byte;
        byte_stb_n = 1'b0;
        rx_ferr_n  = 1'b0;
        case (rx_state)
            R_IDLE: begin
                clk_cnt_n = '0;
                if (!rx_s) rx_state_n = R_START;
            end
            R_START: begin
                // Re-check the start bit at mid-bit; a short low pulse is a glitch.
                if (clk_cnt == HALF_M1) begin
                    clk_cnt_n  = '0;
                    bit_idx_n  = '0;
                    rx_state_n = rx_s ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (clk_cnt == FULL_M1) begin
                    clk_cnt_n = '0;
                    rx_byte_n = {rx_s, rx_byte[7:1]};   // LSB arrives first
                    bit_idx_n = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) rx_state_n = R_STOP;
                end
            end
            R_STOP: begin
                if (clk_cnt == FULL_M1) begin
                    clk_cnt_n  = '0;
                    rx_state_n = R_IDLE;
                    byte_stb_n = rx_s;
                    rx_ferr_n  = !rx_s;
                end
            end
            default: rx_state_n = R_IDLE;
        endcase
    end

    // ---------------- frame parser ----------------
    frame_state_t     f_state, f_state_n;
    logic [SEL_W-1:0] ch_idx, ch_idx_n;
    logic [ACC_W-1:0] data_acc, data_acc_n;
    logic [7:0]       csum, csum_n;
    logic [BC_W-1:0]  nbyte, nbyte_n;
    logic [TO_W-1:0]  tcnt, tcnt_n;
    logic             commit, discard;

    logic [DATA_W-1:0] ch_reg [NUM_CH];
    logic              frame_valid_q, frame_err_q;
    logic [7:0]        err_count_q;

    always_comb begin
        f_state_n  = f_state;
        ch_idx_n   = ch_idx;
        data_acc_n = data_acc;
        csum_n     = csum;
        nbyte_n    = nbyte;
        tcnt_n     = tcnt;
        commit     = 1'b0;
        discard    = 1'b0;

        // Inter-byte idle gap: counts only while a frame is open and the line is idle.
        if (f_state != F_CH && rx_state == R_IDLE) tcnt_n = tcnt + 1'b1;

        if (rx_ferr) begin
            discard = 1'b1;
        end else if (byte_stb) begin
            tcnt_n = '0;
            case (f_state)
                F_CH: begin
                    if (int'(rx_byte) >= NUM_CH) begin
                        discard = 1'b1;
                    end else begin
                        ch_idx_n   = SEL_W'(rx_byte);
                        csum_n     = rx_byte;
                        data_acc_n = '0;
                        nbyte_n    = '0;
                        f_state_n  = F_DATA;
                    end
                end
                F_DATA: begin
                    data_acc_n = (data_acc << 8) | ACC_W'(rx_byte);
                    csum_n     = csum ^ rx_byte;
                    nbyte_n    = nbyte + 1'b1;
                    if (nbyte == LAST_DB) begin
`ifdef IO_LOADER_CHECKSUM_EN
                        f_state_n = F_CSUM;
`else
                        commit = 1'b1;
`endif
                    end
                end
                F_CSUM: begin
                    if (rx_byte == csum) commit  = 1'b1;
                    else                 discard = 1'b1;
                end
                default: discard = 1'b1;
            endcase
        end else if (f_state != F_CH && rx_state == R_IDLE && tcnt == TO_MAX) begin
            discard = 1'b1;
        end

        if (commit || discard) begin
            f_state_n = F_CH;
            tcnt_n    = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            f_state       <= F_CH;
            ch_idx        <= '0;
            data_acc      <= '0;
            csum          <= '0;
            nbyte         <= '0;
            tcnt          <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_count_q   <= '0;
            // NOTE: the channel bank is a handful of flops with a defined power-up value, so it is reset like any other register.
            for (int k = 0; k < NUM_CH; k++) ch_reg[k] <= RESET_VAL;
        end else begin
            f_state       <= f_state_n;
            ch_idx        <= ch_idx_n;
            data_acc      <= data_acc_n;
            csum          <= csum_n;
            nbyte         <= nbyte_n;
            tcnt          <= tcnt_n;
            frame_valid_q <= commit;
            frame_err_q   <= discard;
            if (discard && err_count_q != 8'hFF) err_count_q <= err_count_q + 1'b1;
            for (int k = 0; k < NUM_CH; k++) begin
                if (commit && ch_idx == SEL_W'(k)) ch_reg[k] <= data_acc_n[DATA_W-1:0];
            end
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        bus.data_read = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (bus.sel_read == SEL_W'(k)) bus.data_read = ch_reg[k];
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign bus.ch_data[k*DATA_W +: DATA_W] = ch_reg[k];
    end

    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.err_count   = err_count_q;
endmodule

// File: tb/tb_io_channel_loader.sv
// ----------------------------------------------------------------------------
// tb_io_channel_loader
// Directed bench for io_channel_loader with CLKS_PER_BIT=8, NUM_CH=7,
// DATA_W=15, TIMEOUT_CLKS=160. Frames are built from hand-chosen bytes; the
// checksum byte (when IO_LOADER_CHECKSUM_EN is defined) is the XOR of the
// preceding frame bytes.
// ----------------------------------------------------------------------------
module tb_io_channel_loader;
    localparam int NUM_CH = 7;
    localparam int DATA_W = 15;
    localparam int SEL_W  = 5;
    localparam int CPB    = 8;
    localparam int TO     = 160;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    io_channel_loader_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

    io_channel_loader #(
        .NUM_CH      (NUM_CH),
        .DATA_W      (DATA_W),
        .SEL_W       (SEL_W),
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_CLKS(TO),
        .RESET_VAL   (15'd0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Pulse monitors: count each 1-cycle pulse once and snapshot ch_data on frame_valid.
    int valid_cnt = 0;
    int err_pulse_cnt = 0;
    int both_cnt = 0;
    logic [NUM_CH*DATA_W-1:0] valid_snap = '0;

    always @(posedge clock) begin
        if (bus.frame_valid) begin
            valid_cnt++;
            valid_snap = bus.ch_data;
        end
        if (bus.frame_err) err_pulse_cnt++;
        if (bus.frame_valid && bus.frame_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] ch_of(input int k);
        return bus.ch_data[k*DATA_W +: DATA_W];
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic good_stop);
        bus.rx_serial = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            bus.rx_serial = b[i];
            repeat (CPB) @(negedge clock);
        end
        bus.rx_serial = good_stop;
        repeat (CPB) @(negedge clock);
        bus.rx_serial = 1'b1;
    endtask

    // Channel byte, high data byte, low data byte, optional checksum.
    task automatic send_raw3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
`ifdef IO_LOADER_CHECKSUM_EN
        send_byte(b0 ^ b1 ^ b2, 1'b1);
`endif
        repeat (4) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] ch, input logic [14:0] word);
        send_raw3(ch, {1'b0, word[14:8]}, word[7:0]);
    endtask

    int exp_err;
    int v0, e0;

    initial begin
        reset         = 1'b1;
        bus.rx_serial = 1'b1;
        bus.sel_read  = 5'd3;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Reset state
        check("reset_ch_data",     32'(bus.ch_data == '0), 32'd1);
        check("reset_err_count",   32'(bus.err_count), 32'd0);
        check("reset_data_read",   32'(bus.data_read), 32'd0);
        check("reset_frame_valid", 32'(bus.frame_valid), 32'd0);
        check("reset_frame_err",   32'(bus.frame_err), 32'd0);
        exp_err = 0;

        // Valid frame to ch0
        v0 = valid_cnt; e0 = err_pulse_cnt;
        send_frame(8'h00, 15'd37);
        check("ch0_value",      32'(ch_of(0)), 32'd37);
        check("ch0_one_valid",  32'(valid_cnt - v0), 32'd1);
        check("ch0_no_err",     32'(err_pulse_cnt - e0), 32'd0);
        check("ch0_snap",       32'(valid_snap[0 +: DATA_W]), 32'd37);
        bus.sel_read = 5'd0;
        @(negedge clock);
        check("ch0_data_read",  32'(bus.data_read), 32'd37);

        // Bad channel index
        e0 = err_pulse_cnt; v0 = valid_cnt;
        send_byte(8'h09, 1'b1);
        repeat (4) @(negedge clock);
        exp_err++;
        check("badch_err_pulse", 32'(err_pulse_cnt - e0), 32'd1);
        check("badch_err_count", 32'(bus.err_count), 32'(exp_err));
        check("badch_no_valid",  32'(valid_cnt - v0), 32'd0);
        check("badch_ch0_kept",  32'(ch_of(0)), 32'd37);

        // Timeout: open frame on ch2, then a 200-cycle idle gap.
        e0 = err_pulse_cnt;
        send_byte(8'h02, 1'b1);
        repeat (200) @(negedge clock);
        exp_err++;
        check("timeout_err_pulse", 32'(err_pulse_cnt - e0), 32'd1);
        check("timeout_err_count", 32'(bus.err_count), 32'(exp_err));
        // The late 0x12 and 0x34 now arrive with no open frame: both are out-of-range indices.
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        repeat (4) @(negedge clock);
        exp_err += 2;
        check("timeout_tail_err_count", 32'(bus.err_count), 32'(exp_err));
        check("timeout_ch2_kept",       32'(ch_of(2)), 32'd0);
        send_frame(8'h02, 15'h1234);
        check("ch2_value", 32'(ch_of(2)), 32'h1234);

        // Framing error in a data byte, then in the channel byte.
        v0 = valid_cnt;
        send_byte(8'h04, 1'b1);
        send_byte(8'h11, 1'b0);
        repeat (20) @(negedge clock);
        exp_err++;
        check("ferr_data_err_count", 32'(bus.err_count), 32'(exp_err));
        check("ferr_data_no_valid",  32'(valid_cnt - v0), 32'd0);
        check("ferr_data_ch4_kept",  32'(ch_of(4)), 32'd0);
        send_byte(8'h03, 1'b0);
        repeat (20) @(negedge clock);
        exp_err++;
        check("ferr_ch_err_count", 32'(bus.err_count), 32'(exp_err));

        // Top bit of the first data byte is ignored.
        send_raw3(8'h04, 8'hDA, 8'h5A);
        check("ch4_top_bit_ignored", 32'(ch_of(4)), 32'h5A5A);

        // Short glitch on the line: no byte, no error.
        e0 = err_pulse_cnt; v0 = valid_cnt;
        bus.rx_serial = 1'b0;
        repeat (2) @(negedge clock);
        bus.rx_serial = 1'b1;
        repeat (30) @(negedge clock);
        check("glitch_no_err",   32'(err_pulse_cnt - e0), 32'd0);
        check("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);
        send_frame(8'h06, 15'h7FFF);
        check("ch6_max_value", 32'(ch_of(6)), 32'h7FFF);

        // Checksum handling (or a plain write to ch1 in the default build).
`ifdef IO_LOADER_CHECKSUM_EN
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'hFF, 1'b1);
        repeat (4) @(negedge clock);
        exp_err++;
        check("csum_bad_err_count", 32'(bus.err_count), 32'(exp_err));
        check("csum_bad_ch1_kept",  32'(ch_of(1)), 32'd0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h04, 1'b1);
        repeat (4) @(negedge clock);
`else
        send_frame(8'h01, 15'd5);
`endif
        check("ch1_value", 32'(ch_of(1)), 32'd5);
        check("err_count_stable", 32'(bus.err_count), 32'(exp_err));

        // Read mux: in range and out of range.
        bus.sel_read = 5'd1;
        @(negedge clock);
        check("read_sel1", 32'(bus.data_read), 32'd5);
        bus.sel_read = 5'd7;
        @(negedge clock);
        check("read_sel7_oor", 32'(bus.data_read), 32'd0);
        bus.sel_read = 5'd31;
        @(negedge clock);
        check("read_sel31_oor", 32'(bus.data_read), 32'd0);

        // Back-to-back frames with no idle gap.
        v0 = valid_cnt;
        send_byte(8'h03, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h23, 1'b1);
`ifdef IO_LOADER_CHECKSUM_EN
        send_byte(8'h03 ^ 8'h01 ^ 8'h23, 1'b1);
`endif
        send_byte(8'h05, 1'b1);
        send_byte(8'h43, 1'b1);
        send_byte(8'h21, 1'b1);
`ifdef IO_LOADER_CHECKSUM_EN
        send_byte(8'h05 ^ 8'h43 ^ 8'h21, 1'b1);
`endif
        repeat (4) @(negedge clock);
        check("b2b_ch3",    32'(ch_of(3)), 32'h0123);
        check("b2b_ch5",    32'(ch_of(5)), 32'h4321);
        check("b2b_valids", 32'(valid_cnt - v0), 32'd2);

        // Saturation of the error counter.
        for (int i = 0; i < 256; i++) send_byte(8'h09, 1'b1);
        repeat (4) @(negedge clock);
        check("err_count_saturated", 32'(bus.err_count), 32'd255);
        check("never_valid_and_err", 32'(both_cnt), 32'd0);

        // Asynchronous reset in the middle of a byte.
        bus.rx_serial = 1'b0;
        repeat (CPB) @(negedge clock);
        bus.rx_serial = 1'b1;
        repeat (3 * CPB) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("arst_err_count", 32'(bus.err_count), 32'd0);
        check("arst_ch_data",   32'(bus.ch_data == '0), 32'd1);
        bus.rx_serial = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        e0 = err_pulse_cnt;
        send_frame(8'h00, 15'h0042);
        check("post_arst_ch0",       32'(ch_of(0)), 32'h0042);
        check("post_arst_no_err",    32'(bus.err_count), 32'd0);
        check("post_arst_err_pulse", 32'(err_pulse_cnt - e0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
